// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS control path: FSM states, ALU operations,
// opcode/funct constants, mux select codes and the control-strobe bundle.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_JREG     = 4'd10,
    S_ADDI_EX  = 4'd11,
    S_ADDI_WB  = 4'd12,
    S_HALT     = 4'd15
  } state_e;

  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/alu_op_decode.sv
// R-type funct to ALU operation mapping, shared with the single-cycle decoder.
// funct_ok_c is low for any funct without an ALU operation (jr included).
module alu_op_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op_c,
  output logic       funct_ok_c
);

  always_comb begin
    alu_op_c   = ALU_NONE;
    funct_ok_c = 1'b1;
    case (funct)
      FN_ADD, FN_ADDU: alu_op_c = ALU_ADD;
      FN_SUB, FN_SUBU: alu_op_c = ALU_SUB;
      FN_AND:          alu_op_c = ALU_AND;
      FN_OR:           alu_op_c = ALU_OR;
      FN_NOR:          alu_op_c = ALU_NOR;
      FN_SLT:          alu_op_c = ALU_SLT;
      FN_SLL:          alu_op_c = ALU_SLL;
      FN_SRL:          alu_op_c = ALU_SRL;
      FN_SRA:          alu_op_c = ALU_SRA;
      default:         funct_ok_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with bounded memory waits and a sticky timeout.
// Define ILLEGAL_TRAP_EN to halt on unsupported instructions (illegal_instr).
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       mem_err,
  output logic [3:0] state
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       illegal_instr
`endif
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_err_q, mem_err_d;
  logic              illegal_q, illegal_d;

  logic [3:0] rtype_op_c;
  logic       rtype_ok_c;
  logic       wait_st_c;
  logic       illegal_c;
  state_e     ready_next_c;
  ctrl_t      ctrl_c;
  ctrl_t      ctrl_gated_c;

  // The zero flag is combined with PCWriteCond in the datapath, not here.
  logic unused_zero;
  assign unused_zero = zero;

  alu_op_decode u_alu_op_decode (
    .funct      (funct),
    .alu_op_c   (rtype_op_c),
    .funct_ok_c (rtype_ok_c)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = '0;
    mem_err_d    = mem_err_q;
    illegal_d    = illegal_q;
    ctrl_c       = '0;
    wait_st_c    = 1'b0;
    illegal_c    = 1'b0;
    ready_next_c = S_FETCH;

    case (state_q)
      S_FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.i_or_d    = 1'b0;
        ctrl_c.alu_src_a = 1'b0;
        ctrl_c.alu_src_b = SRCB_FOUR;
        ctrl_c.alu_op    = ALU_ADD;
        ctrl_c.pc_source = PCSRC_ALU;
        ctrl_c.ir_write  = mem_ready;
        ctrl_c.pc_write  = mem_ready;
        wait_st_c        = 1'b1;
        ready_next_c     = S_DECODE;
      end
      S_DECODE: begin
        ctrl_c.alu_src_a = 1'b0;
        ctrl_c.alu_src_b = SRCB_IMM_SH2;
        ctrl_c.alu_op    = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (funct == FN_JR)  state_d = S_JREG;
            else if (rtype_ok_c) state_d = S_RTYPE_EX;
            else                 illegal_c = 1'b1;
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_J:    state_d = S_JUMP;
          OP_ADDI: state_d = S_ADDI_EX;
          default: illegal_c = 1'b1;
        endcase
        if (illegal_c) begin
`ifdef ILLEGAL_TRAP_EN
          state_d   = S_HALT;
          illegal_d = 1'b1;
`else
          state_d           = S_FETCH;
          ctrl_c.instr_done = 1'b1;
`endif
        end
      end
      S_MEMADR: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALU_ADD;
        state_d          = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctrl_c.mem_read = 1'b1;
        ctrl_c.i_or_d   = 1'b1;
        wait_st_c       = 1'b1;
        ready_next_c    = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.reg_dst    = 1'b0;
        ctrl_c.instr_done = 1'b1;
        state_d           = S_FETCH;
      end
      S_MEMWR: begin
        ctrl_c.mem_write  = 1'b1;
        ctrl_c.i_or_d     = 1'b1;
        ctrl_c.instr_done = mem_ready;
        wait_st_c         = 1'b1;
        ready_next_c      = S_FETCH;
      end
      S_RTYPE_EX: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_B;
        ctrl_c.alu_op    = rtype_op_c;
        state_d          = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.reg_dst    = 1'b1;
        ctrl_c.mem_to_reg = 1'b0;
        ctrl_c.alu_op     = rtype_op_c;
        ctrl_c.instr_done = 1'b1;
        state_d           = S_FETCH;
      end
      S_BRANCH: begin
        ctrl_c.alu_src_a     = 1'b1;
        ctrl_c.alu_src_b     = SRCB_B;
        ctrl_c.alu_op        = ALU_SUB;
        ctrl_c.pc_write_cond = 1'b1;
        ctrl_c.pc_source     = PCSRC_ALUOUT;
        ctrl_c.instr_done    = 1'b1;
        state_d              = S_FETCH;
      end
      S_JUMP: begin
        ctrl_c.pc_write   = 1'b1;
        ctrl_c.pc_source  = PCSRC_JUMP;
        ctrl_c.instr_done = 1'b1;
        state_d           = S_FETCH;
      end
      S_JREG: begin
        ctrl_c.pc_write   = 1'b1;
        ctrl_c.pc_source  = PCSRC_REGA;
        ctrl_c.instr_done = 1'b1;
        state_d           = S_FETCH;
      end
      S_ADDI_EX: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALU_ADD;
        state_d          = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.reg_dst    = 1'b0;
        ctrl_c.mem_to_reg = 1'b0;
        ctrl_c.instr_done = 1'b1;
        state_d           = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // Memory wait: a ready in the final allowed cycle still wins over timeout.
    if (wait_st_c) begin
      if (mem_ready) begin
        state_d = ready_next_c;
      end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
        state_d   = S_HALT;
        mem_err_d = 1'b1;
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end
  end

  // Every output reads zero while reset is held low.
  assign ctrl_gated_c = reset_n ? ctrl_c : '0;

  assign PCWrite     = ctrl_gated_c.pc_write;
  assign PCWriteCond = ctrl_gated_c.pc_write_cond;
  assign IorD        = ctrl_gated_c.i_or_d;
  assign IRWrite     = ctrl_gated_c.ir_write;
  assign MemRead     = ctrl_gated_c.mem_read;
  assign MemWrite    = ctrl_gated_c.mem_write;
  assign MemToReg    = ctrl_gated_c.mem_to_reg;
  assign RegWrite    = ctrl_gated_c.reg_write;
  assign RegDst      = ctrl_gated_c.reg_dst;
  assign ALUSrcA     = ctrl_gated_c.alu_src_a;
  assign ALUSrcB     = ctrl_gated_c.alu_src_b;
  assign ALUOp       = ctrl_gated_c.alu_op;
  assign PCSource    = ctrl_gated_c.pc_source;
  assign instr_done  = ctrl_gated_c.instr_done;
  assign mem_err     = reset_n & mem_err_q;
  assign state       = reset_n ? 4'(state_q) : 4'd0;

`ifdef ILLEGAL_TRAP_EN
  assign illegal_instr = reset_n & illegal_q;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_q ^ illegal_d;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboarded random bench for multicycle_control: a per-instruction model
// predicts latency and strobe activity; a monitor checks each retirement.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite;
  logic       MemToReg, RegWrite, RegDst, ALUSrcA, instr_done, mem_err;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] ALUOp, st;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_instr;
`endif

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .instr_done(instr_done),
    .mem_err(mem_err), .state(st)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_instr(illegal_instr)
`endif
  );

  typedef struct {
    int lat, memrd, memwr, regwr, pcw, pcwc, ssum;
    int done_aluop, prev_aluop, done_pcsrc, done_regdst, done_memtoreg;
  } exp_t;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_JR = 3, K_BEQ = 4, K_J = 5, K_ADDI = 6, K_NOP = 7;

  exp_t exp_q[$];
  int   n_pass = 0, n_total = 0, retired = 0;
  int   wf = 0, wd = 0;
  logic [5:0] rfn [11] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                           6'b100101, 6'b100111, 6'b101010, 6'b000000, 6'b000010, 6'b000011};

  function automatic void chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // ALU code for each supported R-type funct, -1 otherwise
  function automatic int r_alu(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100001: return 1;
      6'b100010, 6'b100011: return 2;
      6'b100100: return 3;
      6'b100101: return 4;
      6'b100111: return 5;
      6'b101010: return 6;
      6'b000000: return 7;
      6'b000010: return 8;
      6'b000011: return 9;
      default:   return -1;
    endcase
  endfunction

  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b000010: return K_J;
      6'b001000: return K_ADDI;
      6'b000000: begin
        if (fn == 6'b001000) return K_JR;
        return (r_alu(fn) >= 0) ? K_R : K_NOP;
      end
      default: return K_NOP;
    endcase
  endfunction

  // Expected per-instruction activity: f fetch wait cycles, d data wait cycles
  function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input int f, input int d);
    exp_t e;
    int   k = kind_of(op, fn);
    e.lat = 2 + f; e.memrd = 1 + f; e.memwr = 0; e.regwr = 0; e.pcw = 1; e.pcwc = 0;
    e.ssum = 1; e.done_aluop = 0; e.prev_aluop = 1; e.done_pcsrc = 0;
    e.done_regdst = 0; e.done_memtoreg = 0;
    case (k)
      K_LW: begin
        e.lat += 3 + d; e.memrd += 1 + d; e.regwr = 1; e.ssum += 2 + 3 * (1 + d) + 4;
        e.prev_aluop = 0; e.done_memtoreg = 1;
      end
      K_SW: begin
        e.lat += 2 + d; e.memwr = 1 + d; e.ssum += 2 + 5 * (1 + d);
        e.prev_aluop = (d > 0) ? 0 : 1;
      end
      K_R: begin
        e.lat += 2; e.regwr = 1; e.ssum += 13; e.done_aluop = r_alu(fn);
        e.prev_aluop = r_alu(fn); e.done_regdst = 1;
      end
      K_ADDI: begin e.lat += 2; e.regwr = 1; e.ssum += 23; end
      K_BEQ:  begin e.lat += 1; e.pcwc = 1; e.ssum += 8; e.done_aluop = 2; e.done_pcsrc = 1; end
      K_J:    begin e.lat += 1; e.pcw = 2; e.ssum += 9; e.done_pcsrc = 2; end
      K_JR:   begin e.lat += 1; e.pcw = 2; e.ssum += 10; e.done_pcsrc = 3; end
      default: e.done_aluop = 1;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z, input int f, input int d);
    opcode = op; funct = fn; zero = z; wf = f; wd = d;
    exp_q.push_back(model(op, fn, f, d));
  endtask

  task automatic wait_retire(input string tag);
    int target = retired + 1;
    int ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #3;
      if (retired >= target) begin ok = 1; break; end
    end
    chk({"retire_", tag}, ok, 1);
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, input int f, input int d, input string tag);
    @(negedge clk);
    issue(op, fn, z, f, d);
    wait_retire(tag);
  endtask

  // Memory responder: holds off each access by the configured wait count
  initial begin
    int pend = 0;
    int tgt;
    mem_ready = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (!reset_n) begin
        mem_ready = 1'b0; pend = 0;
      end else if (MemRead || MemWrite) begin
        tgt = IorD ? wd : wf;
        if (pend >= tgt) begin mem_ready = 1'b1; pend = 0; end
        else begin mem_ready = 1'b0; pend++; end
      end else begin
        mem_ready = 1'($urandom); pend = 0;
      end
    end
  end

  // Monitor: accumulate activity per instruction and score it on retirement
  initial begin
    int cnt = 0, a_rd = 0, a_wr = 0, a_rw = 0, a_pw = 0, a_pwc = 0, a_ss = 0, last_op = 0;
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (!reset_n) begin
        cnt = 0; a_rd = 0; a_wr = 0; a_rw = 0; a_pw = 0; a_pwc = 0; a_ss = 0; last_op = 0;
      end else begin
        cnt++;
        a_rd += int'(MemRead); a_wr += int'(MemWrite); a_rw += int'(RegWrite);
        a_pw += int'(PCWrite); a_pwc += int'(PCWriteCond); a_ss += int'(st);
        if (instr_done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_retire", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("latency#%0d", retired), cnt, e.lat);
            chk($sformatf("memread_cycles#%0d", retired), a_rd, e.memrd);
            chk($sformatf("memwrite_cycles#%0d", retired), a_wr, e.memwr);
            chk($sformatf("regwrite_cycles#%0d", retired), a_rw, e.regwr);
            chk($sformatf("pcwrite_cycles#%0d", retired), a_pw, e.pcw);
            chk($sformatf("pcwritecond_cycles#%0d", retired), a_pwc, e.pcwc);
            chk($sformatf("state_sum#%0d", retired), a_ss, e.ssum);
            chk($sformatf("done_aluop#%0d", retired), int'(ALUOp), e.done_aluop);
            chk($sformatf("prev_aluop#%0d", retired), last_op, e.prev_aluop);
            chk($sformatf("done_pcsource#%0d", retired), int'(PCSource), e.done_pcsrc);
            chk($sformatf("done_regdst#%0d", retired), int'(RegDst), e.done_regdst);
            chk($sformatf("done_memtoreg#%0d", retired), int'(MemToReg), e.done_memtoreg);
          end
          retired++;
          cnt = 0; a_rd = 0; a_wr = 0; a_rw = 0; a_pw = 0; a_pwc = 0; a_ss = 0;
        end
        last_op = int'(ALUOp);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] outs_v;
    logic [5:0]  op, fn;
    int          k, nk, n5;
    reset_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0;

    repeat (3) @(negedge clk);
    #3;
    outs_v = 32'({PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemToReg, RegWrite,
                  RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, mem_err, st});
`ifdef ILLEGAL_TRAP_EN
    outs_v = outs_v | 32'(illegal_instr);
`endif
    chk("reset_outputs", int'(outs_v), 0);

    // Directed: lw with zero-wait memory straight out of reset
    @(negedge clk);
    issue(6'b100011, 6'b010101, 1'b0, 0, 0);
    reset_n = 1'b1;
    wait_retire("lw0");
    run(6'b000100, 6'b000000, 1'b1, 0, 0, "beq_taken");
    run(6'b000100, 6'b111111, 1'b0, 1, 0, "beq_not_taken");
    run(6'b000000, 6'b000011, 1'b0, 0, 0, "sra");
    run(6'b101011, 6'b000000, 1'b0, 0, 3, "sw_wait3");
    run(6'b100011, 6'b000000, 1'b0, 2, 15, "lw_wait15");
    run(6'b001000, 6'b000000, 1'b0, 0, 0, "addi");
    run(6'b000010, 6'b000000, 1'b0, 0, 0, "j");
    run(6'b000000, 6'b001000, 1'b0, 0, 0, "jr");
`ifndef ILLEGAL_TRAP_EN
    run(6'b111111, 6'b000000, 1'b0, 0, 0, "illegal_nop");
    run(6'b000000, 6'b000001, 1'b0, 0, 0, "bad_funct_nop");
    nk = 8;
`else
    nk = 7;
`endif

    for (int i = 0; i < 40; i++) begin
      k  = $urandom_range(0, nk - 1);
      fn = 6'($urandom);
      case (k)
        K_LW:   op = 6'b100011;
        K_SW:   op = 6'b101011;
        K_R:    begin op = 6'b000000; fn = rfn[$urandom_range(0, 10)]; end
        K_JR:   begin op = 6'b000000; fn = 6'b001000; end
        K_BEQ:  op = 6'b000100;
        K_J:    op = 6'b000010;
        K_ADDI: op = 6'b001000;
        default: begin
          case ($urandom_range(0, 2))
            0:       op = 6'b111111;
            1:       op = 6'b000101;
            default: begin op = 6'b000000; fn = 6'b000001; end
          endcase
        end
      endcase
      run(op, fn, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rand%0d", i));
    end

    // Reset while a store is stalled in MEMWR
    @(negedge clk);
    opcode = 6'b101011; funct = '0; wf = 0; wd = 6;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #3;
      if (st == 4'd5) break;
    end
    chk("reach_memwr", int'(st), 5);
    @(negedge clk);
    reset_n = 1'b0;
    #3;
    chk("rst_memwrite_low", int'(MemWrite), 0);
    chk("rst_state_low", int'(st), 0);
    @(negedge clk);
    issue(6'b000010, 6'b000000, 1'b0, 0, 0);
    reset_n = 1'b1;
    #3;
    chk("post_rst_state", int'(st), 0);
    chk("post_rst_memwrite", int'(MemWrite), 0);
    wait_retire("j_after_reset");

    // Store whose memory never answers: 16 waiting cycles then HALT
    @(negedge clk);
    opcode = 6'b101011; funct = '0; wf = 0; wd = 1000;
    n5 = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #3;
      if (st == 4'd5) n5++;
      else if (n5 > 0) break;
    end
    chk("timeout_memwr_cycles", n5, 16);
    chk("timeout_state", int'(st), 15);
    chk("timeout_mem_err", int'(mem_err), 1);
    repeat (3) @(negedge clk);
    #3;
    chk("halt_holds", int'(st), 15);
    chk("halt_memwrite", int'(MemWrite), 0);
    chk("mem_err_sticky", int'(mem_err), 1);

    @(negedge clk);
    reset_n = 1'b0;
    #3;
    chk("rst_mem_err_low", int'(mem_err), 0);
    @(negedge clk);
    issue(6'b000010, 6'b000000, 1'b0, 0, 0);
    reset_n = 1'b1;
    #3;
    chk("mem_err_cleared", int'(mem_err), 0);
    wait_retire("j_after_halt");

`ifdef ILLEGAL_TRAP_EN
    @(negedge clk);
    opcode = 6'b111111; funct = '0; wf = 0; wd = 0;
    repeat (3) @(negedge clk);
    #3;
    chk("trap_state", int'(st), 15);
    chk("trap_illegal_instr", int'(illegal_instr), 1);
    chk("trap_mem_err", int'(mem_err), 0);
`endif

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
